// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Shares one 8-digit active-low seven-segment display between two pattern
// requesters. The block owns the scan timing (prescaler, digit scan, anode
// and cathode drive) and grants the display round-robin. Ownership changes
// only at frame boundaries, and a quantum bounds how long one owner can keep
// the display while the other requester waits.

module seg_display_arbiter #(
   parameter int unsigned SCAN_N  = 17,
   parameter int unsigned QUANTUM = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [55:0] seg0,
   input  logic [55:0] seg1,
   output logic [1:0]  gnt,
   output logic [6:0]  CA,
   output logic [7:0]  AN
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   localparam logic [7:0] LP_QLIM = 8'(QUANTUM - 1);

   logic [SCAN_N-1:0] r_prescaler;
   logic [2:0]        r_digit;
   logic [7:0]        r_frame_cnt;
   logic              r_last_owner;
   state_t            r_state;

   logic              w_tick;
   logic              w_frame_end;
   state_t            w_next_state;
   logic              w_quantum_up;
   logic [5:0]        w_idx;
   logic [55:0]       w_seg_sel;

   assign w_tick       = &r_prescaler;
   assign w_frame_end  = w_tick && (r_digit == 3'd7);
   assign w_quantum_up = (r_frame_cnt >= LP_QLIM);

   // 7*digit computed as 8*digit - digit; stays within 6 bits (max 49)
   assign w_idx     = {r_digit, 3'b000} - {3'b000, r_digit};
   assign w_seg_sel = (r_state == ST_OWN1) ? seg1 : seg0;

   // Free-running prescaler and digit scan; digit advances on each tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prescaler <= '0;
         r_digit     <= '0;
      end else begin
         r_prescaler <= r_prescaler + 1'b1;
         if (w_tick) begin
            r_digit <= r_digit + 3'd1;
         end
      end
   end

   // Arbitration decision, only acted on at frame_end
   always_comb begin
      w_next_state = r_state;
      if (w_frame_end) begin
         case (r_state)
            ST_IDLE: begin
               case (req)
                  2'b01:   w_next_state = ST_OWN0;
                  2'b10:   w_next_state = ST_OWN1;
                  2'b11:   w_next_state = r_last_owner ? ST_OWN0 : ST_OWN1;
                  default: w_next_state = ST_IDLE;
               endcase
            end
            ST_OWN0: begin
               if (!req[0]) begin
                  w_next_state = req[1] ? ST_OWN1 : ST_IDLE;
               end else if (req[1] && w_quantum_up) begin
                  w_next_state = ST_OWN1;
               end
            end
            ST_OWN1: begin
               if (!req[1]) begin
                  w_next_state = req[0] ? ST_OWN0 : ST_IDLE;
               end else if (req[0] && w_quantum_up) begin
                  w_next_state = ST_OWN0;
               end
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   // Owner state, grant decode and frame/owner bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         gnt          <= 2'b00;
         r_frame_cnt  <= '0;
         r_last_owner <= 1'b1;
      end else begin
         r_state <= w_next_state;
         case (w_next_state)
            ST_OWN0: gnt <= 2'b01;
            ST_OWN1: gnt <= 2'b10;
            default: gnt <= 2'b00;
         endcase
         if (w_frame_end) begin
            if (w_next_state != r_state) begin
               if (w_next_state == ST_OWN0) begin
                  r_frame_cnt  <= '0;
                  r_last_owner <= 1'b0;
               end else if (w_next_state == ST_OWN1) begin
                  r_frame_cnt  <= '0;
                  r_last_owner <= 1'b1;
               end
            end else if (r_state != ST_IDLE && r_frame_cnt != 8'hFF) begin
               r_frame_cnt <= r_frame_cnt + 8'd1;
            end
         end
      end
   end

   // Registered display drive from the current state and digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AN <= 8'hFF;
         CA <= 7'h7F;
      end else if (r_state == ST_IDLE) begin
         AN <= 8'hFF;
         CA <= 7'h7F;
      end else begin
         AN <= ~(8'b0000_0001 << r_digit);
         CA <= ~w_seg_sel[w_idx +: 7];
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Testbench for seg_display_arbiter with SCAN_N=2 (digit every 4 cycles,
// frame every 32 cycles) and QUANTUM=2. The driver pushes expected
// {gnt, AN, CA} tagged with the cycle count since reset release; the monitor
// pops and compares at the falling edge of that cycle.

module tb_seg_display_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [55:0] seg0;
   logic [55:0] seg1;
   logic [1:0]  gnt;
   logic [6:0]  CA;
   logic [7:0]  AN;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  gnt;
      logic [7:0]  an;
      logic [6:0]  ca;
   } exp_t;

   exp_t        q[$];
   string       nq[$];
   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   exp_t        e;
   string       nm;

   seg_display_arbiter #(.SCAN_N(2), .QUANTUM(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .seg0  (seg0),
      .seg1  (seg1),
      .gnt   (gnt),
      .CA    (CA),
      .AN    (AN)
   );

   always #5 clk = ~clk;

   // Edges since reset release: after edge n the prescaler has counted n
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Monitor: compare every expectation due at this cycle
   always @(negedge clk) begin
      while (q.size() != 0 && q[0].cyc <= cyc) begin
         e  = q.pop_front();
         nm = nq.pop_front();
         total++;
         if (e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", nm, e.cyc, cyc);
         end else if ({gnt, AN, CA} !== {e.gnt, e.an, e.ca}) begin
            bad++;
            $display("FAIL %s @%0d: got gnt=%b AN=%h CA=%h, want gnt=%b AN=%h CA=%h",
                     nm, cyc, gnt, AN, CA, e.gnt, e.an, e.ca);
         end
      end
   end

   task automatic push_raw(input int unsigned n, input logic [1:0] g,
                           input logic [7:0] an, input logic [6:0] ca, input string name);
      exp_t x;
      x.cyc = n; x.gnt = g; x.an = an; x.ca = ca;
      q.push_back(x);
      nq.push_back(name);
   endtask

   // owner: 0/1 = requester shown on the display at cycle n, 2 = blank
   task automatic push(input int unsigned n, input logic [1:0] g, input int owner,
                       input string name);
      int unsigned d;
      logic [55:0] sel;
      logic [7:0]  an;
      logic [6:0]  ca;
      d   = ((n - 1) / 4) % 8;
      sel = (owner == 1) ? seg1 : seg0;
      if (owner == 2) begin
         an = 8'hFF;
         ca = 7'h7F;
      end else begin
         an = ~(8'b0000_0001 << d);
         ca = ~sel[7*d +: 7];
      end
      push_raw(n, g, an, ca, name);
   endtask

   task automatic wait_cyc(input int unsigned n);
      int unsigned k = 0;
      while (cyc < n && k < 20000) begin
         @(negedge clk);
         k++;
      end
      if (cyc != n) begin
         total++;
         bad++;
         $display("FAIL wait_cyc: reached %0d, want %0d", cyc, n);
      end
   endtask

   task automatic drain();
      int unsigned k = 0;
      while (q.size() != 0 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
         q.delete();
         nq.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      req   = 2'b00;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 2'b00;
      for (int k = 0; k < 8; k++) begin
         seg0[7*k +: 7] = 7'h01 << (k % 7);
         seg1[7*k +: 7] = 7'(8 + k);
      end
      push_raw(0, 2'b00, 8'hFF, 7'h7F, "por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single requester, full frame
      req = 2'b01;
      push_raw(31, 2'b00, 8'hFF, 7'h7F, "t2_pre");
      push_raw(32, 2'b01, 8'hFF, 7'h7F, "t2_gnt");
      push_raw(33, 2'b01, 8'hFE, 7'h7E, "t2_d0");
      push_raw(37, 2'b01, 8'hFD, 7'h7D, "t2_d1");
      for (int unsigned d = 2; d < 8; d++) push(33 + 4*d, 2'b01, 0, "t2_scan");
      push_raw(64, 2'b01, 8'h7F, 7'h7E, "t2_d7");
      wait_cyc(70);
      drain();

      // Asynchronous reset while owned; checked before the next rising edge
      @(posedge clk);
      #2;
      push_raw(0, 2'b00, 8'hFF, 7'h7F, "t1_async");
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push(1,  2'b00, 2, "t1_blank1");
      push(16, 2'b00, 2, "t1_blank16");
      push(31, 2'b00, 2, "t1_blank31");
      push(32, 2'b01, 2, "t1_gnt");
      push_raw(33, 2'b01, 8'hFE, 7'h7E, "t1_d0");
      wait_cyc(40);
      drain();

      // Simultaneous first request, quantum round-robin
      do_reset();
      req = 2'b11;
      push(31,  2'b00, 2, "t3_idle");
      push(32,  2'b01, 2, "t3_g0");
      push(33,  2'b01, 0, "t3_own0");
      push(64,  2'b01, 0, "t3_hold");
      push(65,  2'b01, 0, "t3_hold_d0");
      push(95,  2'b01, 0, "t3_pre_sw");
      push(96,  2'b10, 0, "t3_sw1");
      push(97,  2'b10, 1, "t3_own1");
      push(128, 2'b10, 1, "t3_hold1");
      push(159, 2'b10, 1, "t3_pre_sw2");
      push(160, 2'b01, 1, "t3_sw0");
      push(161, 2'b01, 0, "t3_back0");
      wait_cyc(165);
      drain();

      // Owner release with no contender
      do_reset();
      req = 2'b10;
      push(32, 2'b10, 2, "t4_gnt");
      push(33, 2'b10, 1, "t4_d0");
      push(49, 2'b10, 1, "t4_d4");
      push(63, 2'b10, 1, "t4_d7");
      push(64, 2'b00, 1, "t4_drop");
      push(65, 2'b00, 2, "t4_blank");
      push(96, 2'b00, 2, "t4_stay");
      push(97, 2'b00, 2, "t4_stay2");
      wait_cyc(45);
      req = 2'b00;
      wait_cyc(100);
      drain();

      // Handover without tearing, seg0 all segments on
      seg0 = '1;
      do_reset();
      req = 2'b11;
      push(94, 2'b01, 0, "t5_m2");
      push(95, 2'b01, 0, "t5_m1");
      push_raw(96, 2'b10, 8'h7F, 7'h00, "t5_edge");
      push_raw(97, 2'b10, 8'hFE, 7'h77, "t5_new");
      push(98, 2'b10, 1, "t5_p2");
      wait_cyc(100);
      drain();
      for (int k = 0; k < 8; k++) seg0[7*k +: 7] = 7'h01 << (k % 7);

      // Frame counter saturation, then contender arrives
      do_reset();
      req = 2'b01;
      push(9664, 2'b01, 0, "t6_long");
      push(9695, 2'b01, 0, "t6_pre");
      push(9696, 2'b10, 0, "t6_sw");
      push(9697, 2'b10, 1, "t6_own1");
      wait_cyc(9669);
      req = 2'b11;
      wait_cyc(9700);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
